// File: rtl/minisrc_pkg.sv
// Shared encodings for the MiniSRC control unit: opcodes, FSM states, ALU codes,
// datapath mux selects and the decoded instruction class.
package minisrc_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BRZ  = 5'b10010;
  localparam logic [4:0] OP_BRNZ = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;

  localparam logic       MB_RB      = 1'b0;
  localparam logic       MB_IMM     = 1'b1;
  localparam logic       MINC_FOUR  = 1'b0;
  localparam logic       MINC_OFFS  = 1'b1;
  localparam logic       MPC_RA     = 1'b0;
  localparam logic       MPC_ADDER  = 1'b1;
  localparam logic [1:0] MY_RZ0     = 2'd0;
  localparam logic [1:0] MY_RZ1     = 2'd1;
  localparam logic [1:0] MY_MEM     = 2'd2;
  localparam logic [1:0] MY_RET     = 2'd3;
  localparam logic [1:0] MC_RA      = 2'd0;
  localparam logic [1:0] MC_RB      = 2'd1;
  localparam logic [1:0] MC_LINK    = 2'd2;
  localparam logic [1:0] MC_R0      = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALTED
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JUMP, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic [3:0]   alu;
    logic         link;   // JAL: write return address to R15
    logic         br_nz;  // BRNZ: branch when the zero flag is clear
  } decode_t;

endpackage

// File: rtl/minisrc_decode.sv
// Combinational opcode decoder: maps the 5-bit opcode to an instruction class
// plus the ALU code and the jump/branch flavour bits.
module minisrc_decode
  import minisrc_pkg::*;
(
  input  logic [4:0] opcode,
  output decode_t    dec
);

  always_comb begin
    // NOTE: every field gets a default first so no path through the case leaves a latch.
    dec = '{cls: CLS_ILLEGAL, alu: ALU_ADD, link: 1'b0, br_nz: 1'b0};
    case (opcode)
      OP_LD:   dec.cls = CLS_LOAD;
      OP_ADDI: dec.cls = CLS_IMM;
      OP_ST:   dec.cls = CLS_STORE;
      OP_ADD:  dec.cls = CLS_ALU;
      OP_SUB:  begin dec.cls = CLS_ALU;    dec.alu = ALU_SUB; end
      OP_AND:  begin dec.cls = CLS_ALU;    dec.alu = ALU_AND; end
      OP_OR:   begin dec.cls = CLS_ALU;    dec.alu = ALU_OR;  end
      OP_MUL:  begin dec.cls = CLS_MULDIV; dec.alu = ALU_MUL; end
      OP_DIV:  begin dec.cls = CLS_MULDIV; dec.alu = ALU_DIV; end
      OP_BRZ:  dec.cls = CLS_BRANCH;
      OP_BRNZ: begin dec.cls = CLS_BRANCH; dec.br_nz = 1'b1; end
      OP_JR:   dec.cls = CLS_JUMP;
      OP_JAL:  begin dec.cls = CLS_JUMP;   dec.link = 1'b1; end
      OP_NOP:  dec.cls = CLS_NOP;
      OP_HALT: dec.cls = CLS_HALT;
      default: dec.cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/minisrc_control_unit.sv
// Multicycle MiniSRC sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with memory
// wait states, stretched MUL/DIV execute and a sticky halt state.
module minisrc_control_unit
  import minisrc_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iInstr,
  input  logic        iAluZero,
  input  logic        iImemReady,
  input  logic        iMemReady,
  output logic        ir_enable,
  output logic        ra_enable,
  output logic        rb_enable,
  output logic        rm_enable,
  output logic        rz0_enable,
  output logic        rz1_enable,
  output logic        ry_enable,
  output logic        rpc_enable,
  output logic        rpc_temp_enable,
  output logic        mb_select,
  output logic        minc_select,
  output logic        mpc_select,
  output logic [1:0]  my_select,
  output logic [1:0]  mc_select,
  output logic [3:0]  alu_control,
  output logic        rf_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        instruction_mem_read,
  output logic        oInstrDone,
  output logic        oHalted
);

  localparam logic [3:0] MD_LAST = 4'(MULDIV_CYCLES);

  state_e     state;
  logic [3:0] md_cnt;
  decode_t    dec;
  logic       md_last;
  logic       br_taken;
  logic       unused_instr_bits;

  minisrc_decode u_decode (
    .opcode (iInstr[31:27]),
    .dec    (dec)
  );

  assign unused_instr_bits = ^iInstr[26:0];
  assign md_last  = (md_cnt == MD_LAST);
  assign br_taken = dec.br_nz ? !iAluZero : iAluZero;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= S_FETCH;
      md_cnt <= '0;
    end else begin
      case (state)
        S_FETCH:  if (iImemReady) state <= S_DECODE;
        S_DECODE: state <= (dec.cls inside {CLS_HALT, CLS_ILLEGAL}) ? S_HALTED : S_EXECUTE;
        S_EXECUTE: begin
          if (dec.cls == CLS_MULDIV && !md_last) begin
            md_cnt <= md_cnt + 4'd1;
          end else begin
            md_cnt <= '0;
            state  <= S_MEMORY;
          end
        end
        S_MEMORY: begin
          case (dec.cls)
            CLS_LOAD:           if (iMemReady) state <= S_WRITEBACK;
            CLS_STORE:          if (iMemReady) state <= S_FETCH;
            CLS_BRANCH, CLS_NOP: state <= S_FETCH;
            CLS_JUMP:           state <= dec.link ? S_WRITEBACK : S_FETCH;
            default:            state <= S_WRITEBACK;
          endcase
        end
        S_WRITEBACK: state <= S_FETCH;
        S_HALTED:    state <= S_HALTED;
        default:     state <= S_FETCH;
      endcase
    end
  end

  // Outputs are forced low while reset is held so an aborted access drops at once.
  always_comb begin
    ir_enable = 1'b0; ra_enable = 1'b0; rb_enable = 1'b0; rm_enable = 1'b0;
    rz0_enable = 1'b0; rz1_enable = 1'b0; ry_enable = 1'b0; rpc_enable = 1'b0;
    rpc_temp_enable = 1'b0; mb_select = MB_RB; minc_select = MINC_FOUR;
    mpc_select = MPC_RA; my_select = MY_RZ0; mc_select = MC_RA; alu_control = ALU_ADD;
    rf_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; instruction_mem_read = 1'b0;
    oInstrDone = 1'b0; oHalted = 1'b0;
    if (!iRst) begin
      case (state)
        S_FETCH: begin
          instruction_mem_read = 1'b1;
          if (iImemReady) begin
            ir_enable  = 1'b1;
            rpc_enable = 1'b1;
            mpc_select = MPC_ADDER;
          end
        end
        S_DECODE: begin
          ra_enable       = 1'b1;
          rb_enable       = 1'b1;
          rpc_temp_enable = 1'b1;
        end
        S_EXECUTE: begin
          alu_control = dec.alu;
          mb_select   = (dec.cls inside {CLS_IMM, CLS_LOAD, CLS_STORE}) ? MB_IMM : MB_RB;
          rz0_enable  = (dec.cls inside {CLS_ALU, CLS_IMM, CLS_LOAD, CLS_STORE})
                        || (dec.cls == CLS_MULDIV && md_last);
          rz1_enable  = (dec.cls == CLS_MULDIV) && md_last;
          rm_enable   = (dec.cls == CLS_STORE);
        end
        S_MEMORY: begin
          case (dec.cls)
            CLS_LOAD: begin
              mem_read = 1'b1;
              if (iMemReady) begin
                my_select = MY_MEM;
                ry_enable = 1'b1;
              end
            end
            CLS_STORE: begin
              mem_write  = 1'b1;
              oInstrDone = iMemReady;
            end
            CLS_BRANCH: begin
              oInstrDone = 1'b1;
              if (br_taken) begin
                rpc_enable  = 1'b1;
                mpc_select  = MPC_ADDER;
                minc_select = MINC_OFFS;
              end
            end
            CLS_JUMP: begin
              rpc_enable = 1'b1;
              mpc_select = MPC_RA;
              if (dec.link) begin
                my_select = MY_RET;
                ry_enable = 1'b1;
              end else begin
                oInstrDone = 1'b1;
              end
            end
            CLS_NOP: oInstrDone = 1'b1;
            CLS_ALU, CLS_IMM, CLS_MULDIV: begin
              my_select = MY_RZ0;
              ry_enable = 1'b1;
            end
            default: ;
          endcase
        end
        S_WRITEBACK: begin
          rf_write   = 1'b1;
          mc_select  = dec.link ? MC_LINK : MC_RA;
          oInstrDone = 1'b1;
        end
        S_HALTED: oHalted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minisrc_control_unit.sv
// Scoreboard bench for minisrc_control_unit: directed per-cycle vectors push the
// hand-derived control word; a negedge monitor pops and compares it.
module tb_minisrc_control_unit;

  localparam logic [4:0] LD = 5'b00000, ADDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011;
  localparam logic [4:0] OR_ = 5'b00110, MUL = 5'b01111, DIV = 5'b10000, BRZ = 5'b10010;
  localparam logic [4:0] BRNZ = 5'b10011, JR = 5'b10100, JAL = 5'b10101, NOP = 5'b11010;
  localparam logic [4:0] HALT = 5'b11011, ILL = 5'b11111;

  typedef struct packed {
    logic ir, ra, rb, rm, rz0, rz1, ry, rpc, rpct, mb, minc, mpc;
    logic [1:0] my, mc;
    logic [3:0] alu;
    logic rfw, mrd, mwr, imrd, done, halted;
  } exp_t;

  typedef struct {
    string name;
    exp_t  v;
  } item_t;

  logic        iClk = 1'b1;
  logic        iRst = 1'b1;
  logic [31:0] iInstr = '0;
  logic        iAluZero = 1'b0, iImemReady = 1'b0, iMemReady = 1'b0;
  logic ir_enable, ra_enable, rb_enable, rm_enable, rz0_enable, rz1_enable, ry_enable;
  logic rpc_enable, rpc_temp_enable, mb_select, minc_select, mpc_select;
  logic [1:0] my_select, mc_select;
  logic [3:0] alu_control;
  logic rf_write, mem_read, mem_write, instruction_mem_read, oInstrDone, oHalted;

  item_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 iClk = ~iClk;

  minisrc_control_unit #(.MULDIV_CYCLES(4)) dut (
    .iClk(iClk), .iRst(iRst), .iInstr(iInstr), .iAluZero(iAluZero),
    .iImemReady(iImemReady), .iMemReady(iMemReady),
    .ir_enable(ir_enable), .ra_enable(ra_enable), .rb_enable(rb_enable),
    .rm_enable(rm_enable), .rz0_enable(rz0_enable), .rz1_enable(rz1_enable),
    .ry_enable(ry_enable), .rpc_enable(rpc_enable), .rpc_temp_enable(rpc_temp_enable),
    .mb_select(mb_select), .minc_select(minc_select), .mpc_select(mpc_select),
    .my_select(my_select), .mc_select(mc_select), .alu_control(alu_control),
    .rf_write(rf_write), .mem_read(mem_read), .mem_write(mem_write),
    .instruction_mem_read(instruction_mem_read), .oInstrDone(oInstrDone), .oHalted(oHalted)
  );

  function automatic exp_t z();
    return '0;
  endfunction

  function automatic exp_t fe(input logic rdy);
    exp_t e = '0;
    e.imrd = 1'b1; e.ir = rdy; e.rpc = rdy; e.mpc = rdy;
    return e;
  endfunction

  function automatic exp_t de();
    exp_t e = '0;
    e.ra = 1'b1; e.rb = 1'b1; e.rpct = 1'b1;
    return e;
  endfunction

  function automatic exp_t ex(input logic [3:0] alu, input logic mb, rz0, rz1, rm);
    exp_t e = '0;
    e.alu = alu; e.mb = mb; e.rz0 = rz0; e.rz1 = rz1; e.rm = rm;
    return e;
  endfunction

  function automatic exp_t me(input logic [1:0] my, input logic ry, rpc, mpc, minc, mrd, mwr, done);
    exp_t e = '0;
    e.my = my; e.ry = ry; e.rpc = rpc; e.mpc = mpc; e.minc = minc;
    e.mrd = mrd; e.mwr = mwr; e.done = done;
    return e;
  endfunction

  function automatic exp_t wb(input logic [1:0] mc);
    exp_t e = '0;
    e.rfw = 1'b1; e.mc = mc; e.done = 1'b1;
    return e;
  endfunction

  function automatic exp_t hl();
    exp_t e = '0;
    e.halted = 1'b1;
    return e;
  endfunction

  // One clock cycle of stimulus plus the control word expected during it.
  task automatic step(input string name, input logic [4:0] op,
                      input logic rst, imem, mem, zero, input exp_t v);
    item_t it;
    iInstr = {op, 27'h5a5a5a5};
    iRst = rst; iImemReady = imem; iMemReady = mem; iAluZero = zero;
    it.name = name; it.v = v;
    sb.push_back(it);
    @(posedge iClk);
    #1;
  endtask

  initial begin : monitor
    item_t it;
    exp_t  act;
    forever begin
      @(negedge iClk);
      if (sb.size() != 0) begin
        it = sb.pop_front();
        act = '{ir: ir_enable, ra: ra_enable, rb: rb_enable, rm: rm_enable,
                rz0: rz0_enable, rz1: rz1_enable, ry: ry_enable, rpc: rpc_enable,
                rpct: rpc_temp_enable, mb: mb_select, minc: minc_select, mpc: mpc_select,
                my: my_select, mc: mc_select, alu: alu_control, rfw: rf_write,
                mrd: mem_read, mwr: mem_write, imrd: instruction_mem_read,
                done: oInstrDone, halted: oHalted};
        n_vec++;
        if (act !== it.v) begin
          n_err++;
          $display("FAIL %s: got %b required %b", it.name, act, it.v);
        end
      end
    end
  end

  initial begin : stimulus
    step("reset",        NOP, 1, 1, 1, 0, z());
    step("fetch_wait",   ADD, 0, 0, 0, 0, fe(0));
    // ADD with zero-wait memories: 5 cycles, ready inputs outside their states ignored
    step("add_fetch",    ADD, 0, 1, 1, 0, fe(1));
    step("add_decode",   ADD, 0, 1, 1, 0, de());
    step("add_exec",     ADD, 0, 1, 1, 0, ex(4'b0000, 0, 1, 0, 0));
    step("add_mem",      ADD, 0, 1, 1, 0, me(2'd0, 1, 0, 0, 0, 0, 0, 0));
    step("add_wb",       ADD, 0, 1, 1, 0, wb(2'd0));
    // LD with three wait states on data memory
    step("ld_fetch",     LD, 0, 1, 0, 0, fe(1));
    step("ld_decode",    LD, 0, 0, 0, 0, de());
    step("ld_exec",      LD, 0, 0, 0, 0, ex(4'b0000, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      step("ld_mem_wait", LD, 0, 1, 0, 0, me(2'd0, 0, 0, 0, 0, 1, 0, 0));
    step("ld_mem_ready", LD, 0, 0, 1, 0, me(2'd2, 1, 0, 0, 0, 1, 0, 0));
    step("ld_wb",        LD, 0, 0, 0, 0, wb(2'd0));
    // MUL then DIV: execute stretched to five cycles, counter must restart
    step("mul_fetch",    MUL, 0, 1, 0, 0, fe(1));
    step("mul_decode",   MUL, 0, 0, 0, 0, de());
    for (int i = 0; i < 4; i++)
      step("mul_exec_hold", MUL, 0, 1, 1, 0, ex(4'b0101, 0, 0, 0, 0));
    step("mul_exec_last", MUL, 0, 0, 0, 0, ex(4'b0101, 0, 1, 1, 0));
    step("mul_mem",      MUL, 0, 0, 0, 0, me(2'd0, 1, 0, 0, 0, 0, 0, 0));
    step("mul_wb",       MUL, 0, 0, 0, 0, wb(2'd0));
    step("div_fetch",    DIV, 0, 1, 0, 0, fe(1));
    step("div_decode",   DIV, 0, 0, 0, 0, de());
    for (int i = 0; i < 4; i++)
      step("div_exec_hold", DIV, 0, 0, 0, 0, ex(4'b0100, 0, 0, 0, 0));
    step("div_exec_last", DIV, 0, 0, 0, 0, ex(4'b0100, 0, 1, 1, 0));
    step("div_mem",      DIV, 0, 0, 0, 0, me(2'd0, 1, 0, 0, 0, 0, 0, 0));
    step("div_wb",       DIV, 0, 0, 0, 0, wb(2'd0));
    // Branches: BRZ taken / not taken, BRNZ taken
    step("brz_t_fetch",  BRZ, 0, 1, 0, 1, fe(1));
    step("brz_t_decode", BRZ, 0, 0, 0, 1, de());
    step("brz_t_exec",   BRZ, 0, 0, 0, 1, ex(4'b0000, 0, 0, 0, 0));
    step("brz_t_mem",    BRZ, 0, 0, 0, 1, me(2'd0, 0, 1, 1, 1, 0, 0, 1));
    step("brz_n_fetch",  BRZ, 0, 1, 0, 0, fe(1));
    step("brz_n_decode", BRZ, 0, 0, 0, 0, de());
    step("brz_n_exec",   BRZ, 0, 0, 0, 0, ex(4'b0000, 0, 0, 0, 0));
    step("brz_n_mem",    BRZ, 0, 0, 0, 0, me(2'd0, 0, 0, 0, 0, 0, 0, 1));
    step("brnz_fetch",   BRNZ, 0, 1, 0, 0, fe(1));
    step("brnz_decode",  BRNZ, 0, 0, 0, 0, de());
    step("brnz_exec",    BRNZ, 0, 0, 0, 0, ex(4'b0000, 0, 0, 0, 0));
    step("brnz_mem",     BRNZ, 0, 0, 0, 0, me(2'd0, 0, 1, 1, 1, 0, 0, 1));
    // JAL links through WRITEBACK; JR returns straight to FETCH
    step("jal_fetch",    JAL, 0, 1, 0, 0, fe(1));
    step("jal_decode",   JAL, 0, 0, 0, 0, de());
    step("jal_exec",     JAL, 0, 0, 0, 0, ex(4'b0000, 0, 0, 0, 0));
    step("jal_mem",      JAL, 0, 0, 0, 0, me(2'd3, 1, 1, 0, 0, 0, 0, 0));
    step("jal_wb",       JAL, 0, 0, 0, 0, wb(2'd2));
    step("jr_fetch",     JR, 0, 1, 0, 0, fe(1));
    step("jr_decode",    JR, 0, 0, 0, 0, de());
    step("jr_exec",      JR, 0, 0, 0, 0, ex(4'b0000, 0, 0, 0, 0));
    step("jr_mem",       JR, 0, 0, 0, 0, me(2'd0, 0, 1, 0, 0, 0, 0, 1));
    // ADDI and OR: immediate select and ALU code
    step("addi_fetch",   ADDI, 0, 1, 0, 0, fe(1));
    step("addi_decode",  ADDI, 0, 0, 0, 0, de());
    step("addi_exec",    ADDI, 0, 0, 0, 0, ex(4'b0000, 1, 1, 0, 0));
    step("addi_mem",     ADDI, 0, 0, 0, 0, me(2'd0, 1, 0, 0, 0, 0, 0, 0));
    step("addi_wb",      ADDI, 0, 0, 0, 0, wb(2'd0));
    step("or_fetch",     OR_, 0, 1, 0, 0, fe(1));
    step("or_decode",    OR_, 0, 0, 0, 0, de());
    step("or_exec",      OR_, 0, 0, 0, 0, ex(4'b0010, 0, 1, 0, 0));
    step("or_mem",       OR_, 0, 0, 0, 0, me(2'd0, 1, 0, 0, 0, 0, 0, 0));
    step("or_wb",        OR_, 0, 0, 0, 0, wb(2'd0));
    // NOP and ST with one wait state
    step("nop_fetch",    NOP, 0, 1, 0, 0, fe(1));
    step("nop_decode",   NOP, 0, 0, 0, 0, de());
    step("nop_exec",     NOP, 0, 0, 0, 0, ex(4'b0000, 0, 0, 0, 0));
    step("nop_mem",      NOP, 0, 0, 0, 0, me(2'd0, 0, 0, 0, 0, 0, 0, 1));
    step("st_fetch",     ST, 0, 1, 0, 0, fe(1));
    step("st_decode",    ST, 0, 0, 0, 0, de());
    step("st_exec",      ST, 0, 0, 0, 0, ex(4'b0000, 1, 1, 0, 1));
    step("st_mem_wait",  ST, 0, 0, 0, 0, me(2'd0, 0, 0, 0, 0, 0, 1, 0));
    step("st_mem_ready", ST, 0, 0, 1, 0, me(2'd0, 0, 0, 0, 0, 0, 1, 1));
    // Reset in the middle of a store, then an illegal opcode halts
    step("st2_fetch",    ST, 0, 1, 0, 0, fe(1));
    step("st2_decode",   ST, 0, 0, 0, 0, de());
    step("st2_exec",     ST, 0, 0, 0, 0, ex(4'b0000, 1, 1, 0, 1));
    step("st2_mem_wait", ST, 0, 0, 0, 0, me(2'd0, 0, 0, 0, 0, 0, 1, 0));
    step("st2_rst_abort", ST, 1, 1, 1, 0, z());
    step("ill_fetch",    ILL, 0, 1, 1, 0, fe(1));
    step("ill_decode",   ILL, 0, 1, 1, 0, de());
    for (int i = 0; i < 3; i++)
      step("ill_halted", ILL, 0, 1, 1, 1, hl());
    // HALT opcode after a fresh reset
    step("halt_reset",   HALT, 1, 0, 0, 0, z());
    step("halt_fetch",   HALT, 0, 1, 0, 0, fe(1));
    step("halt_decode",  HALT, 0, 1, 0, 0, de());
    step("halt_halted",  HALT, 0, 1, 1, 0, hl());
    step("halt_sticky",  ADD, 0, 1, 1, 0, hl());
    step("final_reset",  ADD, 1, 1, 0, 0, z());
    step("final_fetch",  ADD, 0, 0, 0, 0, fe(0));

    @(negedge iClk);
    @(negedge iClk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
